// File: rtl/qtr_emu_pkg.sv
// Shared constants and channel state encoding for the QTRX sensor emulator.
package qtr_emu_pkg;

    localparam int TTD_W       = 17;
    localparam int MIN_CHARGE  = 160;
    localparam int DEFAULT_TTD = 1000;
    localparam int DARK_TTD    = 100000;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        CHARGE = 2'b01,
        DECAY  = 2'b10
    } ch_state_e;

endpackage

// File: rtl/qtr_emu_channel.sv
// One emulated reflectance channel: charge detection, timed decay, and its TTD register.
module qtr_emu_channel
    import qtr_emu_pkg::*;
#(
    parameter int TTD_W_P       = TTD_W,
    parameter int MIN_CHARGE_P  = MIN_CHARGE,
    parameter int DEFAULT_TTD_P = DEFAULT_TTD,
    parameter int DARK_TTD_P    = DARK_TTD
) (
    input  logic               WF_CLK,
    input  logic               reset,
    input  logic               drv_en,
    input  logic               drv_val,
    input  logic               emit,
    input  logic [2:0]         noise,
    input  logic               cfg_we,
    input  logic [TTD_W_P-1:0] cfg_ttd,
    output logic               model,
    output logic               decay_busy,
    output logic               decay_done
);

    localparam int   CW          = $clog2(MIN_CHARGE_P + 1);
    localparam logic FULL_AT_ONE = (MIN_CHARGE_P <= 1);

    ch_state_e          state;
    logic [CW-1:0]      chg_cnt;
    logic [CW-1:0]      chg_inc;
    logic [TTD_W_P-1:0] dec_cnt;
    logic [TTD_W_P-1:0] ttd_reg;
    logic [TTD_W_P-1:0] base_ttd;
    logic [TTD_W_P:0]   ttd_sum;
    logic [TTD_W_P-1:0] eff_ttd;

    // Emitter and noise are sampled combinationally so the release edge sees this cycle's values.
    always_comb begin
        base_ttd = emit ? ttd_reg : TTD_W_P'(DARK_TTD_P);
        ttd_sum  = {1'b0, base_ttd} + (TTD_W_P + 1)'(noise);
        eff_ttd  = ttd_sum[TTD_W_P] ? {TTD_W_P{1'b1}} : ttd_sum[TTD_W_P-1:0];
        if (eff_ttd == '0)
            eff_ttd = TTD_W_P'(1);
        chg_inc  = (chg_cnt >= CW'(MIN_CHARGE_P)) ? chg_cnt : chg_cnt + 1'b1;
    end

    assign decay_busy = (state == DECAY);

    // In CHARGE, model holds "fully charged" so a partial release reads low on the first
    // undriven cycle. A full release's own cycle is the first high cycle, so DECAY runs eff_ttd-1.
    always_ff @(posedge WF_CLK) begin
        if (reset) begin
            state      <= IDLE;
            model      <= 1'b0;
            chg_cnt    <= '0;
            dec_cnt    <= '0;
            ttd_reg    <= TTD_W_P'(DEFAULT_TTD_P);
            decay_done <= 1'b0;
        end else begin
            decay_done <= 1'b0;
            if (cfg_we)
                ttd_reg <= cfg_ttd;
            case (state)
                IDLE: begin
                    if (drv_en && drv_val) begin
                        state   <= CHARGE;
                        chg_cnt <= CW'(1);
                        model   <= FULL_AT_ONE;
                    end
                end
                CHARGE: begin
                    if (drv_en) begin
                        if (drv_val) begin
                            chg_cnt <= chg_inc;
                            model   <= (chg_inc >= CW'(MIN_CHARGE_P));
                        end else begin
                            state   <= IDLE;
                            chg_cnt <= '0;
                            model   <= 1'b0;
                        end
                    end else if (chg_cnt >= CW'(MIN_CHARGE_P)) begin
                        chg_cnt <= '0;
                        if (eff_ttd == TTD_W_P'(1)) begin
                            state      <= IDLE;
                            model      <= 1'b0;
                            decay_done <= 1'b1;
                        end else begin
                            state   <= DECAY;
                            dec_cnt <= eff_ttd - 1'b1;
                            model   <= 1'b1;
                        end
                    end else begin
                        state   <= IDLE;
                        chg_cnt <= '0;
                        model   <= 1'b0;
                    end
                end
                DECAY: begin
                    if (drv_en) begin
                        dec_cnt <= '0;
                        if (drv_val) begin
                            state   <= CHARGE;
                            chg_cnt <= CW'(1);
                            model   <= FULL_AT_ONE;
                        end else begin
                            state <= IDLE;
                            model <= 1'b0;
                        end
                    end else if (dec_cnt <= TTD_W_P'(1)) begin
                        state      <= IDLE;
                        dec_cnt    <= '0;
                        model      <= 1'b0;
                        decay_done <= 1'b1;
                    end else begin
                        dec_cnt <= dec_cnt - 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    model <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/qtr_sensor_emulator.sv
// QTRX sensor-side emulator: NCH independent channels, TTD config port, line resolution.
// Optional decay jitter from a 16-bit LFSR when QTR_EMU_NOISE_EN is defined.
module qtr_sensor_emulator
    import qtr_emu_pkg::*;
#(
    parameter int NCH           = 8,
    parameter int TTD_W_P       = TTD_W,
    parameter int MIN_CHARGE_P  = MIN_CHARGE,
    parameter int DEFAULT_TTD_P = DEFAULT_TTD,
    parameter int DARK_TTD_P    = DARK_TTD
) (
    input  logic               WF_CLK,
    input  logic               reset,
    input  logic [NCH-1:0]     drv_en,
    input  logic [NCH-1:0]     drv_val,
    input  logic               emit_even,
    input  logic               emit_odd,
    output logic [NCH-1:0]     line,
    input  logic               cfg_valid,
    input  logic [2:0]         cfg_ch,
    input  logic [TTD_W_P-1:0] cfg_ttd,
    output logic               cfg_ready,
    output logic [NCH-1:0]     decay_busy,
    output logic [NCH-1:0]     decay_done
);

    logic [NCH-1:0] model;
    logic [2:0]     noise;

    assign cfg_ready = 1'b1;
    assign line      = (drv_en & drv_val) | (~drv_en & model);

`ifdef QTR_EMU_NOISE_EN
    logic [15:0] lfsr;

    // Right-shifting Galois form of taps 16,14,13,11.
    always_ff @(posedge WF_CLK) begin
        if (reset)
            lfsr <= 16'hACE1;
        else
            lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    end

    assign noise = lfsr[2:0];
`else
    assign noise = 3'b000;
`endif

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        qtr_emu_channel #(
            .TTD_W_P       (TTD_W_P),
            .MIN_CHARGE_P  (MIN_CHARGE_P),
            .DEFAULT_TTD_P (DEFAULT_TTD_P),
            .DARK_TTD_P    (DARK_TTD_P)
        ) u_ch (
            .WF_CLK     (WF_CLK),
            .reset      (reset),
            .drv_en     (drv_en[i]),
            .drv_val    (drv_val[i]),
            .emit       ((i % 2 == 0) ? emit_even : emit_odd),
            .noise      (noise),
            .cfg_we     (cfg_valid && cfg_ready && (cfg_ch == 3'(i))),
            .cfg_ttd    (cfg_ttd),
            .model      (model[i]),
            .decay_busy (decay_busy[i]),
            .decay_done (decay_done[i])
        );
    end

endmodule
